// File: rtl/text_painter_pipe_pkg.sv
// Shared constants, text-cell layout and width helpers for the text-mode painter.
package text_painter_pipe_pkg;

    localparam int TXT_COLS = 80;
    localparam int TXT_ROWS = 30;
    localparam int FONT_W   = 8;
    localparam int FONT_H   = 16;
    localparam int CODE_W   = 7;
    localparam int COLOR_W  = 24;

    localparam int CELL_ADDR_W  = $clog2(TXT_COLS * TXT_ROWS);
    localparam int GLYPH_ADDR_W = CODE_W + $clog2(FONT_H);

    typedef struct packed {
        logic [COLOR_W-1:0] fg;
        logic               inverse;
        logic [CODE_W-1:0]  code;
    } text_cell_t;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/text_painter_pipe_blink.sv
// Cursor blink timer: toggles blink_phase every BLINK_FRAMES frame_start pulses.
module blink_timer
    import text_painter_pipe_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    output logic blink_phase
);

    localparam int CNT_W = clog2_min1(BLINK_FRAMES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_start) begin
            if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;

endmodule

// File: rtl/text_painter_pipe.sv
// Three-stage text-mode pixel renderer: cell fetch, glyph fetch, colour select.
module text_painter_pipe
    import text_painter_pipe_pkg::*;
#(
    parameter int COLS         = TXT_COLS,
    parameter int ROWS         = TXT_ROWS,
    parameter int FONT_W       = 8,
    parameter int FONT_H       = 16,
    parameter int CODE_W       = 7,
    parameter int COLOR_W      = 24,
    parameter int BLINK_FRAMES = 30,
    parameter int COORD_W      = 10
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    input  logic [COORD_W-1:0]                      h_coord,
    input  logic [COORD_W-1:0]                      v_coord,
    input  logic                                    frame_start,
    input  logic [COLOR_W-1:0]                      bg_color,
    input  logic                                    cursor_en,
    input  logic [$clog2(COLS)-1:0]                 cursor_col,
    input  logic [$clog2(ROWS)-1:0]                 cursor_row,
    output logic [$clog2(COLS*ROWS)-1:0]            cell_addr,
    input  logic [COLOR_W+1+CODE_W-1:0]             cell_data,
    output logic [CODE_W+$clog2(FONT_H)-1:0]        glyph_addr,
    input  logic [FONT_W-1:0]                       glyph_data,
    output logic                                    out_valid,
    output logic                                    pixel_on,
    output logic [COLOR_W-1:0]                      rgb
);

    localparam int XB_W   = $clog2(FONT_W);
    localparam int YL_W   = $clog2(FONT_H);
    localparam int COL_W  = COORD_W - XB_W;
    localparam int ROW_W  = COORD_W - YL_W;
    localparam int CA_W   = $clog2(COLS * ROWS);
    localparam int GA_W   = CODE_W + YL_W;
    localparam int CELL_W = COLOR_W + 1 + CODE_W;

    logic blink_phase;

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .blink_phase (blink_phase)
    );

    // S0 decode
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             in_area;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_area_q, s1_area_d;
    logic [XB_W-1:0]  s1_xbit_q, s1_xbit_d;
    logic [YL_W-1:0]  s1_yline_q, s1_yline_d;
    logic             s1_cursor_q, s1_cursor_d;
    logic [CA_W-1:0]  cell_addr_q, cell_addr_d;

    logic               s2_valid_q, s2_valid_d;
    logic               s2_area_q, s2_area_d;
    logic [XB_W-1:0]    s2_xbit_q, s2_xbit_d;
    logic [YL_W-1:0]    s2_yline_q, s2_yline_d;
    logic               s2_cursor_q, s2_cursor_d;
    logic [COLOR_W-1:0] s2_fg_q, s2_fg_d;
    logic               s2_inverse_q, s2_inverse_d;
    logic [GA_W-1:0]    glyph_addr_q, glyph_addr_d;

    logic [XB_W-1:0]    bit_idx;
    logic               glyph_bit;
    logic               on;

    logic               out_valid_q, out_valid_d;
    logic               pixel_on_q, pixel_on_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;

    always_comb begin
        col         = h_coord[COORD_W-1:XB_W];
        row         = v_coord[COORD_W-1:YL_W];
        in_area     = in_valid && (int'(col) < COLS) && (int'(row) < ROWS);
        s1_valid_d  = in_valid;
        s1_area_d   = in_area;
        s1_xbit_d   = h_coord[XB_W-1:0];
        s1_yline_d  = v_coord[YL_W-1:0];
        // Out-of-range cursor coordinates only ever equal out-of-area cells, which S2 blanks.
        s1_cursor_d = cursor_en && (int'(col) == int'(cursor_col))
                                && (int'(row) == int'(cursor_row));
        cell_addr_d = '0;
        if (in_area) begin
            cell_addr_d = CA_W'(row) * CA_W'(COLS) + CA_W'(col);
        end
    end

    always_comb begin
        s2_valid_d   = s1_valid_q;
        s2_area_d    = s1_area_q;
        s2_xbit_d    = s1_xbit_q;
        s2_yline_d   = s1_yline_q;
        s2_cursor_d  = s1_cursor_q;
        s2_fg_d      = cell_data[CELL_W-1 -: COLOR_W];
        s2_inverse_d = cell_data[CODE_W];
        glyph_addr_d = {cell_data[CODE_W-1:0], s1_yline_q};
    end

    always_comb begin
        bit_idx   = XB_W'(FONT_W - 1) - s2_xbit_q;
        glyph_bit = glyph_data[bit_idx];
        on        = glyph_bit ^ s2_inverse_q;
        if (s2_cursor_q && blink_phase && (s2_yline_q >= YL_W'(FONT_H - 2))) begin
            on = ~on;
        end
        if (!s2_area_q) begin
            on = 1'b0;
        end
        out_valid_d = s2_valid_q;
        pixel_on_d  = on && s2_valid_q;
        rgb_d       = '0;
        if (s2_valid_q) begin
            rgb_d = on ? s2_fg_q : bg_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_area_q    <= 1'b0;
            s1_xbit_q    <= '0;
            s1_yline_q   <= '0;
            s1_cursor_q  <= 1'b0;
            cell_addr_q  <= '0;
            s2_valid_q   <= 1'b0;
            s2_area_q    <= 1'b0;
            s2_xbit_q    <= '0;
            s2_yline_q   <= '0;
            s2_cursor_q  <= 1'b0;
            s2_fg_q      <= '0;
            s2_inverse_q <= 1'b0;
            glyph_addr_q <= '0;
            out_valid_q  <= 1'b0;
            pixel_on_q   <= 1'b0;
            rgb_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_area_q    <= s1_area_d;
            s1_xbit_q    <= s1_xbit_d;
            s1_yline_q   <= s1_yline_d;
            s1_cursor_q  <= s1_cursor_d;
            cell_addr_q  <= cell_addr_d;
            s2_valid_q   <= s2_valid_d;
            s2_area_q    <= s2_area_d;
            s2_xbit_q    <= s2_xbit_d;
            s2_yline_q   <= s2_yline_d;
            s2_cursor_q  <= s2_cursor_d;
            s2_fg_q      <= s2_fg_d;
            s2_inverse_q <= s2_inverse_d;
            glyph_addr_q <= glyph_addr_d;
            out_valid_q  <= out_valid_d;
            pixel_on_q   <= pixel_on_d;
            rgb_q        <= rgb_d;
        end
    end

    assign cell_addr  = cell_addr_q;
    assign glyph_addr = glyph_addr_q;
    assign out_valid  = out_valid_q;
    assign pixel_on   = pixel_on_q;
    assign rgb        = rgb_q;

endmodule

// File: tb/tb_text_painter_pipe.sv
// Directed bench for text_painter_pipe with hand-computed expectations (BLINK_FRAMES=2).
module tb_text_painter_pipe;
    import text_painter_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [9:0]  h_coord;
    logic [9:0]  v_coord;
    logic        frame_start;
    logic [23:0] bg_color;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [11:0] cell_addr;
    logic [31:0] cell_data;
    logic [10:0] glyph_addr;
    logic [7:0]  glyph_data;
    logic        out_valid;
    logic        pixel_on;
    logic [23:0] rgb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_painter_pipe #(
        .COLS         (80),
        .ROWS         (30),
        .FONT_W       (8),
        .FONT_H       (16),
        .CODE_W       (7),
        .COLOR_W      (24),
        .BLINK_FRAMES (2),
        .COORD_W      (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .h_coord     (h_coord),
        .v_coord     (v_coord),
        .frame_start (frame_start),
        .bg_color    (bg_color),
        .cursor_en   (cursor_en),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .cell_addr   (cell_addr),
        .cell_data   (cell_data),
        .glyph_addr  (glyph_addr),
        .glyph_data  (glyph_data),
        .out_valid   (out_valid),
        .pixel_on    (pixel_on),
        .rgb         (rgb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_cell(input logic [23:0] fg, input logic inv, input logic [6:0] code);
        text_cell_t c;
        c.fg      = fg;
        c.inverse = inv;
        c.code    = code;
        return c;
    endfunction

    // One isolated pixel; checks each stage at the falling edge after it registers.
    task automatic run_pixel(input string tag, input logic v, input logic [9:0] h, input logic [9:0] vc,
                             input logic [11:0] exp_ca, input logic [10:0] exp_ga,
                             input logic exp_ov, input logic exp_on, input logic [23:0] exp_rgb);
        @(negedge clk);
        in_valid = v;
        h_coord  = h;
        v_coord  = vc;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".cell_addr"}, 32'(cell_addr), 32'(exp_ca));
        @(negedge clk);
        chk({tag, ".glyph_addr"}, 32'(glyph_addr), 32'(exp_ga));
        @(negedge clk);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
        chk({tag, ".pixel_on"}, 32'(pixel_on), 32'(exp_on));
        chk({tag, ".rgb"}, 32'(rgb), 32'(exp_rgb));
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        h_coord     = '0;
        v_coord     = '0;
        frame_start = 1'b0;
        bg_color    = 24'h0000FF;
        cursor_en   = 1'b0;
        cursor_col  = 7'd2;
        cursor_row  = 5'd1;
        cell_data   = '0;
        glyph_data  = '0;
        repeat (3) @(negedge clk);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.pixel_on", 32'(pixel_on), 32'd0);
        chk("reset.rgb", 32'(rgb), 32'd0);
        chk("reset.cell_addr", 32'(cell_addr), 32'd0);
        chk("reset.glyph_addr", 32'(glyph_addr), 32'd0);
        rst_n = 1'b1;

        cell_data  = mk_cell(24'hFF0000, 1'b0, 7'h41);
        glyph_data = 8'b1000_0000;
        run_pixel("cell0_h0", 1'b1, 10'd0, 10'd0, 12'd0, 11'h410, 1'b1, 1'b1, 24'hFF0000);
        run_pixel("cell0_h1", 1'b1, 10'd1, 10'd0, 12'd0, 11'h410, 1'b1, 1'b0, 24'h0000FF);

        glyph_data = 8'b0000_0001;
        run_pixel("last_on", 1'b1, 10'd639, 10'd479, 12'd2399, 11'h41F, 1'b1, 1'b1, 24'hFF0000);
        glyph_data = 8'b1111_1110;
        run_pixel("last_off", 1'b1, 10'd639, 10'd479, 12'd2399, 11'h41F, 1'b1, 1'b0, 24'h0000FF);

        cell_data  = mk_cell(24'h00FF00, 1'b1, 7'h41);
        glyph_data = 8'b1000_0000;
        run_pixel("inv_bit1", 1'b1, 10'd0, 10'd0, 12'd0, 11'h410, 1'b1, 1'b0, 24'h0000FF);
        glyph_data = 8'b0000_0000;
        run_pixel("inv_bit0", 1'b1, 10'd0, 10'd0, 12'd0, 11'h410, 1'b1, 1'b1, 24'h00FF00);

        cell_data  = mk_cell(24'hFF0000, 1'b0, 7'h41);
        glyph_data = 8'hFF;
        run_pixel("oob_h700", 1'b1, 10'd700, 10'd10, 12'd0, 11'h41A, 1'b1, 1'b0, 24'h0000FF);
        run_pixel("oob_h640", 1'b1, 10'd640, 10'd0, 12'd0, 11'h410, 1'b1, 1'b0, 24'h0000FF);
        run_pixel("oob_v480", 1'b1, 10'd0, 10'd480, 12'd0, 11'h410, 1'b1, 1'b0, 24'h0000FF);
        run_pixel("not_valid", 1'b0, 10'd0, 10'd0, 12'd0, 11'h410, 1'b0, 1'b0, 24'h000000);

        cursor_en  = 1'b1;
        cell_data  = mk_cell(24'h123456, 1'b0, 7'h20);
        glyph_data = 8'h00;
        run_pixel("cur_f0", 1'b1, 10'd16, 10'd30, 12'd82, 11'h20E, 1'b1, 1'b0, 24'h0000FF);
        pulse_frame();
        run_pixel("cur_f1", 1'b1, 10'd16, 10'd30, 12'd82, 11'h20E, 1'b1, 1'b0, 24'h0000FF);
        pulse_frame();
        run_pixel("cur_f2_y14", 1'b1, 10'd16, 10'd30, 12'd82, 11'h20E, 1'b1, 1'b1, 24'h123456);
        run_pixel("cur_f2_y15", 1'b1, 10'd16, 10'd31, 12'd82, 11'h20F, 1'b1, 1'b1, 24'h123456);
        run_pixel("cur_f2_y13", 1'b1, 10'd16, 10'd29, 12'd82, 11'h20D, 1'b1, 1'b0, 24'h0000FF);
        run_pixel("cur_f2_col3", 1'b1, 10'd24, 10'd30, 12'd83, 11'h20E, 1'b1, 1'b0, 24'h0000FF);
        cursor_en = 1'b0;
        run_pixel("cur_f2_dis", 1'b1, 10'd16, 10'd30, 12'd82, 11'h20E, 1'b1, 1'b0, 24'h0000FF);
        cursor_en = 1'b1;
        pulse_frame();
        run_pixel("cur_f3", 1'b1, 10'd16, 10'd30, 12'd82, 11'h20E, 1'b1, 1'b1, 24'h123456);
        pulse_frame();
        run_pixel("cur_f4", 1'b1, 10'd16, 10'd30, 12'd82, 11'h20E, 1'b1, 1'b0, 24'h0000FF);
        cursor_en = 1'b0;

        cell_data  = mk_cell(24'hABCDEF, 1'b0, 7'h05);
        glyph_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            h_coord  = 10'(i);
            v_coord  = 10'd0;
        end
        chk("stream.out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 32'd0);
        chk("async_rst.pixel_on", 32'(pixel_on), 32'd0);
        chk("async_rst.rgb", 32'(rgb), 32'd0);
        chk("async_rst.cell_addr", 32'(cell_addr), 32'd0);
        chk("async_rst.glyph_addr", 32'(glyph_addr), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle.out_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1;
        h_coord  = 10'd0;
        @(negedge clk);
        chk("post_rst_lat1.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_lat2.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_lat3.out_valid", 32'(out_valid), 32'd1);
        chk("post_rst_lat3.pixel_on", 32'(pixel_on), 32'd1);
        chk("post_rst_lat3.rgb", 32'(rgb), 32'hABCDEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
